shift_sequencer: RTL and testbench

Multi-cycle shift unit that applies one of five single-bit shift/rotate operations to an 8-bit operand a programmable number of times (0..7). It sits directly upstream of, and wraps, the combinational single-step shifter. It captures a request, iterates the step logic once per clock, and hands the result downstream. Valid/ready handshakes on both sides let it be dropped between a register file read port and the writeback register in the lab datapath.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 28 ++
 rtl/shift_sequencer.sv | 89 ++++++++
 tb/tb_shift_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Holds the single-step op codes and the sequencer state encoding.
package shift_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_LSL = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_LSR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Ports:
//   op_i : operation code (reserved codes pass the operand through unchanged)
//   d_i  : operand
//   q_o  : operand after one step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_comb begin
        q_o = d_i;
        case (op_i)
            OP_ROL:  q_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            OP_ROR:  q_o = {d_i[0], d_i[WIDTH-1:1]};
            OP_LSL:  q_o = {d_i[WIDTH-2:0], 1'b0};
            OP_ASR:  q_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            OP_LSR:  q_o = {1'b0, d_i[WIDTH-1:1]};
            default: q_o = d_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: captures a request, applies one single-bit step
// per clock for in_amt cycles, then holds the result until consumed.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : request handshake (ready only while idle)
//   in_data/in_op/in_amt  : operand, op code, step count
//   out_valid/out_ready   : result handshake
//   out_data/out_err      : result and reserved-op flag
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | one step per edge, cnt_q steps remaining
// DONE  | result presented, waiting for out_ready
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic             err_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i (op_q),
        .d_i  (data_q),
        .q_o  (data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= OP_ROL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        op_q    <= in_op;
                        cnt_q   <= in_amt;
                        err_q   <= (in_op > OP_LSR);
                        state_q <= (in_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    // Exit on the last step so the counter never wraps.
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Going back through IDLE guarantees at least one idle cycle
                    // between consuming a result and accepting the next request.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_op = 3'b000;
    logic [2:0] in_amt = 3'b000;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_err;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] exp_data;
        logic       exp_err;
        int         hold;
    } vec_t;

    // Closed-form reference: n steps of an op collapse into a single
    // rotate/shift by n.
    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] d, input int n);
        int v;
        int s;
        v = int'(d);
        case (op)
            3'd0: v = ((v << n) | (v >> (8 - n))) & 255;
            3'd1: v = ((v >> n) | (v << (8 - n))) & 255;
            3'd2: v = (v << n) & 255;
            3'd3: begin
                s = (v >= 128) ? v - 256 : v;
                v = (s >>> n) & 255;
            end
            3'd4: v = v >> n;
            default: v = v;
        endcase
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic do_req(input string name, input logic [2:0] op, input logic [7:0] d,
                          input logic [2:0] amt, input logic [7:0] exp_d, input logic exp_e,
                          input int hold);
        int cyc;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = amt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_op    = 3'($urandom);
        in_amt   = 3'($urandom);
        @(negedge clk);
        check({name, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "/latency"}, 32'(cyc), 32'(amt));
        check({name, "/out_data"}, 32'(out_data), 32'(exp_d));
        check({name, "/out_err"}, 32'(out_err), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "/hold_data"}, 32'(out_data), 32'(exp_d));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "/consumed_valid"}, 32'(out_valid), 32'd0);
        check({name, "/consumed_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"rol_81_1",   3'b000, 8'h81, 3'd1, 8'h03, 1'b0, 0});
        vecs.push_back('{"asr_80_3",   3'b011, 8'h80, 3'd3, 8'hF0, 1'b0, 0});
        vecs.push_back('{"lsr_f0_7",   3'b100, 8'hF0, 3'd7, 8'h01, 1'b0, 0});
        vecs.push_back('{"lsl_a5_0",   3'b010, 8'hA5, 3'd0, 8'hA5, 1'b0, 0});
        vecs.push_back('{"ror_01_2",   3'b001, 8'h01, 3'd2, 8'h40, 1'b0, 5});
        vecs.push_back('{"rsv6_5a_4",  3'b110, 8'h5A, 3'd4, 8'h5A, 1'b1, 0});
        vecs.push_back('{"ror_01_1",   3'b001, 8'h01, 3'd1, 8'h80, 1'b0, 0});
        vecs.push_back('{"lsl_ff_7",   3'b010, 8'hFF, 3'd7, 8'h80, 1'b0, 1});
        vecs.push_back('{"asr_7f_7",   3'b011, 8'h7F, 3'd7, 8'h00, 1'b0, 0});
        vecs.push_back('{"asr_c0_7",   3'b011, 8'hC0, 3'd7, 8'hFF, 1'b0, 0});
        vecs.push_back('{"rol_80_7",   3'b000, 8'h80, 3'd7, 8'h40, 1'b0, 0});
        vecs.push_back('{"rsv7_33_0",  3'b111, 8'h33, 3'd0, 8'h33, 1'b1, 2});
        vecs.push_back('{"rsv5_c3_7",  3'b101, 8'hC3, 3'd7, 8'hC3, 1'b1, 0});

        // Reset state
        #12;
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out_data", 32'(out_data), 32'd0);
        check("reset/out_err", 32'(out_err), 32'd0);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_req(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].amt,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].hold);
        end

        // Second request offered during DONE is ignored, then taken at m+1.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_op    = 3'b010;
        in_amt   = 3'd0;
        @(posedge clk);
        #1;
        in_data  = 8'h0F;
        in_op    = 3'b000;
        in_amt   = 3'd1;
        @(negedge clk);
        check("dbl/first_valid", 32'(out_valid), 32'd1);
        check("dbl/first_data", 32'(out_data), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dbl/ignored_ready", 32'(in_ready), 32'd0);
            check("dbl/ignored_data", 32'(out_data), 32'hA5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("dbl/m_valid", 32'(out_valid), 32'd0);
        check("dbl/m_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("dbl/m1_accepted", 32'(in_ready), 32'd0);
        check("dbl/m1_not_done", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("dbl/second_valid", 32'(out_valid), 32'd1);
        check("dbl/second_data", 32'(out_data), 32'h1E);
        check("dbl/second_err", 32'(out_err), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a shift.
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_op    = 3'b000;
        in_amt   = 3'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/out_valid", 32'(out_valid), 32'd0);
        check("rst_mid/out_data", 32'(out_data), 32'd0);
        check("rst_mid/out_err", 32'(out_err), 32'd0);
        check("rst_mid/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req("rst_after", 3'b000, 8'h01, 3'd6, 8'h40, 1'b0, 0);

        // Randomized requests against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] d;
            logic [2:0] amt;
            op  = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            amt = 3'($urandom_range(0, 7));
            do_req("rand", op, d, amt, ref_result(op, d, int'(amt)), (op > 3'd4),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
